// File: rtl/sim_run_ctrl.sv
// Run controller for a simulated processor: holds it in reset, then enables it
// free-running, single-stepped or until halt, counting enabled cycles.
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 25,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             halt,
    input  logic             abort,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int unsigned RW = 8;

    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_HALT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      mode_q;
    logic [RW-1:0]   rst_cnt;
    logic            start_ok;
    logic            cnt_inc;
    logic            set_timeout;
    logic            at_last;
    logic            rst_last;

    assign at_last  = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
    assign rst_last = (rst_cnt == RW'(RESET_CYCLES - 1));

    // Next-state, counter-enable and state-decoded outputs
    always_comb begin
        state_nxt   = state;
        start_ok    = 1'b0;
        cnt_inc     = 1'b0;
        set_timeout = 1'b0;
        cpu_reset   = 1'b0;
        cpu_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_reset = 1'b1;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = S_RST;
                end
            end
            S_RST: begin
                cpu_reset = 1'b1;
                cpu_en    = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (rst_last) begin
                    state_nxt = (mode_q == MODE_STEP) ? S_STEP : S_RUN;
                end
            end
            S_RUN: begin
                cpu_en = 1'b1;
                busy   = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if ((mode_q == MODE_HALT) && halt) begin
                        state_nxt = S_DONE;
                    end else if (at_last) begin
                        state_nxt   = S_DONE;
                        set_timeout = (mode_q == MODE_HALT);
                    end
                end
            end
            S_STEP: begin
                cpu_en = step;
                busy   = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (step) begin
                    cnt_inc = 1'b1;
                    if (at_last) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = S_RST;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, latched mode, reset-phase counter, cycle counter and timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= 2'd0;
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_RST) && (state_nxt == S_RST)) begin
                rst_cnt <= rst_cnt + RW'(1);
            end else begin
                rst_cnt <= '0;
            end
            if (start_ok) begin
                mode_q    <= mode;
                cycle_cnt <= '0;
                timeout   <= 1'b0;
            end else begin
                if (cnt_inc) begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
                if (set_timeout) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: default instance plus a minimal 1/1 instance.
module tb_sim_run_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        step;
    logic        halt;
    logic        abort;
    logic        cpu_reset;
    logic        cpu_en;
    logic [15:0] cycle_cnt;
    logic        busy;
    logic        done;
    logic        timeout;

    logic        start1;
    logic [1:0]  mode1;
    logic        step1;
    logic        halt1;
    logic        abort1;
    logic        cpu_reset1;
    logic        cpu_en1;
    logic [15:0] cycle_cnt1;
    logic        busy1;
    logic        done1;
    logic        timeout1;

    int ncmp;
    int nfail;

    sim_run_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .step      (step),
        .halt      (halt),
        .abort     (abort),
        .cpu_reset (cpu_reset),
        .cpu_en    (cpu_en),
        .cycle_cnt (cycle_cnt),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    sim_run_ctrl #(.RESET_CYCLES(1), .MAX_CYCLES(1), .CNT_W(16)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .mode      (mode1),
        .step      (step1),
        .halt      (halt1),
        .abort     (abort1),
        .cpu_reset (cpu_reset1),
        .cpu_en    (cpu_en1),
        .cycle_cnt (cycle_cnt1),
        .busy      (busy1),
        .done      (done1),
        .timeout   (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a start and advance through the two reset cycles into RUN/STEP
    task automatic start_run(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        ncmp   = 0;
        nfail  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mode   = 2'd0;
        step   = 1'b0;
        halt   = 1'b0;
        abort  = 1'b0;
        start1 = 1'b0;
        mode1  = 2'd0;
        step1  = 1'b0;
        halt1  = 1'b0;
        abort1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cpu_en",    32'(cpu_en),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        check("rst_cnt",       32'(cycle_cnt), 32'd0);

        // Mode 0: two reset cycles then 25 run cycles; halt and mode change ignored
        mode  = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("m0_rst1_cpu_reset", 32'(cpu_reset), 32'd1);
        check("m0_rst1_cpu_en",    32'(cpu_en),    32'd1);
        check("m0_rst1_busy",      32'(busy),      32'd1);
        tick();
        check("m0_rst2_cpu_reset", 32'(cpu_reset), 32'd1);
        check("m0_rst2_cpu_en",    32'(cpu_en),    32'd1);
        tick();
        for (int i = 0; i < 25; i++) begin
            halt = (i == 9);
            mode = (i >= 9) ? 2'd2 : 2'd0;
            check("m0_run_cpu_reset", 32'(cpu_reset), 32'd0);
            check("m0_run_cpu_en",    32'(cpu_en),    32'd1);
            check("m0_run_cnt",       32'(cycle_cnt), 32'(i));
            tick();
        end
        halt = 1'b0;
        mode = 2'd0;
        check("m0_done",    32'(done),      32'd1);
        check("m0_cnt",     32'(cycle_cnt), 32'd25);
        check("m0_timeout", 32'(timeout),   32'd0);
        check("m0_cpu_en",  32'(cpu_en),    32'd0);
        check("m0_busy",    32'(busy),      32'd0);
        tick();
        check("m0_done_hold_cnt", 32'(cycle_cnt), 32'd25);

        // Mode 2: halt in 10th run cycle; restart from DONE clears count
        mode  = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("m2a_rst_cnt",  32'(cycle_cnt), 32'd0);
        check("m2a_rst_done", 32'(done),      32'd0);
        tick();
        tick();
        for (int i = 0; i < 9; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("m2a_done",    32'(done),      32'd1);
        check("m2a_cnt",     32'(cycle_cnt), 32'd10);
        check("m2a_timeout", 32'(timeout),   32'd0);

        // Mode 2 without halt: limit reached -> timeout
        start_run(2'd2);
        for (int i = 0; i < 25; i++) tick();
        check("m2b_done",    32'(done),      32'd1);
        check("m2b_cnt",     32'(cycle_cnt), 32'd25);
        check("m2b_timeout", 32'(timeout),   32'd1);

        // Mode 2, halt coincides with limit: halt wins; timeout cleared by start
        mode  = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("m2c_rst_timeout", 32'(timeout), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 24; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("m2c_done",    32'(done),      32'd1);
        check("m2c_cnt",     32'(cycle_cnt), 32'd25);
        check("m2c_timeout", 32'(timeout),   32'd0);

        // Mode 1: three single-cycle steps, then step held 4 cycles; halt ignored
        start_run(2'd1);
        check("m1_entry_busy", 32'(busy),      32'd1);
        check("m1_entry_cnt",  32'(cycle_cnt), 32'd0);
        halt = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                step = (k == 0);
                #1;
                check("m1_cpu_en_pulse", 32'(cpu_en), 32'(step));
                tick();
            end
        end
        for (int k = 0; k < 4; k++) begin
            step = 1'b1;
            #1;
            check("m1_cpu_en_held", 32'(cpu_en), 32'd1);
            tick();
        end
        step = 1'b0;
        halt = 1'b0;
        #1;
        check("m1_cpu_en_low", 32'(cpu_en),    32'd0);
        check("m1_cnt",        32'(cycle_cnt), 32'd7);
        check("m1_busy",       32'(busy),      32'd1);
        check("m1_done",       32'(done),      32'd0);
        // Abort beats step; count held
        abort = 1'b1;
        step  = 1'b1;
        tick();
        abort = 1'b0;
        step  = 1'b0;
        check("m1_abort_busy", 32'(busy),      32'd0);
        check("m1_abort_cnt",  32'(cycle_cnt), 32'd7);

        // Reset mid-run at count 12
        start_run(2'd0);
        for (int i = 0; i < 12; i++) tick();
        check("rr_pre_cnt", 32'(cycle_cnt), 32'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rr_cpu_en",    32'(cpu_en),    32'd0);
        check("rr_cnt",       32'(cycle_cnt), 32'd0);
        check("rr_busy",      32'(busy),      32'd0);

        // Start during RUN ignored; abort at count 5
        start_run(2'd0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_start_busy", 32'(busy),      32'd1);
        check("ab_start_rst",  32'(cpu_reset), 32'd0);
        check("ab_start_cnt",  32'(cycle_cnt), 32'd3);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy",      32'(busy),      32'd0);
        check("ab_cnt",       32'(cycle_cnt), 32'd5);
        check("ab_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ab_done",      32'(done),      32'd0);

        // Abort beats limit at count 24 (mode 2 also sees halt)
        start_run(2'd2);
        for (int i = 0; i < 24; i++) tick();
        abort = 1'b1;
        halt  = 1'b1;
        tick();
        abort = 1'b0;
        halt  = 1'b0;
        check("abl_done",    32'(done),      32'd0);
        check("abl_busy",    32'(busy),      32'd0);
        check("abl_cnt",     32'(cycle_cnt), 32'd24);
        check("abl_timeout", 32'(timeout),   32'd0);

        // Minimal instance: one reset cycle, one run cycle, then done
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("min_rst_cpu_reset", 32'(cpu_reset1), 32'd1);
        check("min_rst_cpu_en",    32'(cpu_en1),    32'd1);
        tick();
        check("min_run_cpu_reset", 32'(cpu_reset1), 32'd0);
        check("min_run_cpu_en",    32'(cpu_en1),    32'd1);
        check("min_run_done",      32'(done1),      32'd0);
        tick();
        check("min_done",   32'(done1),      32'd1);
        check("min_cnt",    32'(cycle_cnt1), 32'd1);
        check("min_cpu_en", 32'(cpu_en1),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
